// File: rtl/tap_mac8_pkg.sv
// Shared definitions for the tap_mac8 multiply-accumulate scanner:
// FSM state encoding and default geometry constants.
package tap_mac8_pkg;

    localparam int DEF_N    = 8;
    localparam int DEF_C    = 8;
    localparam int DEF_TAPS = 8;
    localparam int DEF_AW   = $clog2(DEF_TAPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tap_mac8_coef_rf.sv
// Coefficient register file: TAPS x C flops, synchronous write with
// enable, combinational read so the MAC sees the coefficient same-cycle.
module coef_rf #(
    parameter int C    = 8,
    parameter int TAPS = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [C-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [C-1:0]  rd_data
);

    logic [C-1:0] coef_q [TAPS];
    logic [C-1:0] coef_d [TAPS];

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_entry
            always_comb begin
                coef_d[gi] = coef_q[gi];
                if (we && (wr_addr == AW'(gi))) begin
                    coef_d[gi] = wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < TAPS; i++) begin
            if (!rst) begin
                coef_q[i] <= '0;
            end else begin
                coef_q[i] <= coef_d[i];
            end
        end
    end

    assign rd_data = coef_q[rd_addr];

endmodule

// File: rtl/tap_mac8.sv
// Scans TAPS taps of an upstream addressable shift register, accumulates
// coef[k]*tap[k] and presents the sum with a valid/ready handshake.
module tap_mac8
    import tap_mac8_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int C    = DEF_C,
    parameter int TAPS = DEF_TAPS,
    localparam int AW  = $clog2(TAPS),
    localparam int RW  = N + C + AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  tap_in,
    output logic [AW-1:0] addr,
    output logic          busy,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [C-1:0]  coef_data,
    output logic [RW-1:0] result,
    output logic          valid,
    input  logic          ready
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW-1:0] result_q, result_d;
    logic          valid_q, valid_d;

    logic [AW-1:0]  coef_rd_addr;
    logic [C-1:0]   coef_rd;
    logic [N+C-1:0] prod;
    logic [RW-1:0]  acc_sum;
    logic           cnt_last;

    coef_rf #(
        .C    (C),
        .TAPS (TAPS),
        .AW   (AW)
    ) u_coef_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (coef_we && (state_q == ST_IDLE)),
        .wr_addr (coef_addr),
        .wr_data (coef_data),
        .rd_addr (coef_rd_addr),
        .rd_data (coef_rd)
    );

    // tap_in lags addr by one cycle, so scan cycle k+1 pairs with coef[k]
    assign coef_rd_addr = cnt_q[AW-1:0] - AW'(1);
    assign prod         = (N+C)'(coef_rd) * (N+C)'(tap_in);
    assign acc_sum      = (cnt_q != '0) ? (acc_q + RW'(prod)) : acc_q;
    assign cnt_last     = (cnt_q == (AW+1)'(TAPS));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_SCAN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + (AW+1)'(1);
                if (addr_q != AW'(TAPS - 1)) begin
                    addr_d = addr_q + AW'(1);
                end
                if (cnt_last) begin
                    state_d  = ST_DONE;
                    result_d = acc_sum;
                    valid_d  = 1'b1;
                    addr_d   = '0;
                    cnt_d    = '0;
                end
            end
            ST_DONE: begin
                if (valid_q && ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign addr   = addr_q;
    assign busy   = (state_q != ST_IDLE);
    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_tap_mac8.sv
// Directed bench for tap_mac8; upstream shift register modelled as
// tap_in = addr+1 with one cycle of latency (optionally forced to 255).
module tb_tap_mac8;

    localparam int N  = 8;
    localparam int C  = 8;
    localparam int AW = 3;
    localparam int RW = N + C + AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  tap_q = '0;
    logic [AW-1:0] addr;
    logic          busy;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [C-1:0]  coef_data = '0;
    logic [RW-1:0] result;
    logic          valid;
    logic          ready = 1'b0;
    logic          force_max = 1'b0;

    int errors = 0;
    int checks = 0;

    tap_mac8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tap_in    (tap_q),
        .addr      (addr),
        .busy      (busy),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .result    (result),
        .valid     (valid),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tap_q <= force_max ? 8'hFF : ({5'b0, addr} + 8'd1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int k, input int v);
        coef_we   = 1'b1;
        coef_addr = k[AW-1:0];
        coef_data = v[C-1:0];
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic load_all(input int v);
        for (int k = 0; k < 8; k++) write_coef(k, v);
    endtask

    // Pulses start and waits (bounded) for valid; lat counts edges incl. the start edge.
    task automatic run_scan(output logic [RW-1:0] res, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 40) begin
            tick();
            lat++;
        end
        res = result;
    endtask

    task automatic handshake;
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (addr !== 3'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        checks++; if (result !== 19'd0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
        rst = 1'b1;
        tick();
        $display("reset: addr=%0d busy=%0b valid=%0b result=%0d", addr, busy, valid, result);
    endtask

    task automatic test_basic;
        logic [AW-1:0] seen [9];
        int lat;
        load_all(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        seen[0] = addr;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        for (int i = 1; i < 9; i++) begin
            tick();
            seen[i] = addr;
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (seen[i] !== ((i < 8) ? 3'(i) : 3'd7)) begin
                errors++; $display("FAIL basic_addr[%0d] got=%0d exp=%0d", i, seen[i], (i < 8) ? i : 7);
            end
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0b exp=0", valid); end
        lat = 9;
        while (!valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (lat != 10) begin errors++; $display("FAIL basic_latency got=%0d exp=10", lat); end
        checks++; if (result !== 19'd36) begin errors++; $display("FAIL basic_result got=%0d exp=36", result); end
        $display("basic: latency=%0d result=%0d", lat, result);
        handshake();
    endtask

    task automatic test_ramp;
        logic [RW-1:0] res;
        int lat;
        for (int k = 0; k < 8; k++) write_coef(k, k);
        run_scan(res, lat);
        checks++; if (res !== 19'd168) begin errors++; $display("FAIL ramp_result got=%0d exp=168", res); end
        $display("ramp: latency=%0d result=%0d", lat, res);
        handshake();
    endtask

    task automatic test_max;
        logic [RW-1:0] res;
        int lat;
        load_all(255);
        force_max = 1'b1;
        run_scan(res, lat);
        force_max = 1'b0;
        checks++; if (res !== 19'd520200) begin errors++; $display("FAIL max_result got=%0d exp=520200", res); end
        $display("max: latency=%0d result=%0d", lat, res);
        handshake();
    endtask

    task automatic test_backpressure;
        logic [RW-1:0] res;
        int lat;
        load_all(1);
        run_scan(res, lat);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, valid); end
            checks++; if (result !== 19'd36) begin errors++; $display("FAIL bp_result[%0d] got=%0d exp=36", i, result); end
        end
        start = 1'b1;
        handshake();
        start = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got=%0b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_drop got=%0b exp=0", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored got=%0b exp=0", busy); end
        checks++; if (result !== 19'd36) begin errors++; $display("FAIL bp_result_hold got=%0d exp=36", result); end
        $display("backpressure: valid=%0b busy=%0b result=%0d", valid, busy, result);
    endtask

    task automatic test_coef_during_scan;
        logic [RW-1:0] res;
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd99;
        tick();
        coef_we = 1'b0;
        lat = 2;
        while (!valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++; if (result !== 19'd36) begin errors++; $display("FAIL scanwr_cur got=%0d exp=36", result); end
        $display("coef_during_scan: current result=%0d", result);
        handshake();
        run_scan(res, lat);
        checks++; if (res !== 19'd36) begin errors++; $display("FAIL scanwr_next got=%0d exp=36", res); end
        $display("coef_during_scan: next result=%0d", res);
        handshake();
    endtask

    task automatic test_reset_mid_scan;
        logic [RW-1:0] res;
        int lat;
        int vcount;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++; if (addr !== 3'd0) begin errors++; $display("FAIL midrst_addr got=%0d exp=0", addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", valid); end
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid) vcount++;
        end
        checks++; if (vcount != 0) begin errors++; $display("FAIL midrst_no_valid got=%0d exp=0", vcount); end
        load_all(1);
        run_scan(res, lat);
        checks++; if (res !== 19'd36) begin errors++; $display("FAIL midrst_rerun got=%0d exp=36", res); end
        checks++; if (lat != 10) begin errors++; $display("FAIL midrst_latency got=%0d exp=10", lat); end
        $display("reset_mid_scan: rerun latency=%0d result=%0d", lat, res);
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ramp();
        test_max();
        test_backpressure();
        test_coef_during_scan();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tap_mac8.md
TAP_MAC8 -- requirements
Module: tap_mac8

Interface
REQ-001 Parameter N, default 8: width of tap data from the addressable shift register.
REQ-002 Parameter C, default 8: unsigned coefficient width.
REQ-003 Parameter TAPS, default 8: number of taps scanned; power of two; AW = log2(TAPS) = 3.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset:
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous active-low reset.
- start  in  1: request one multiply-accumulate scan; sampled only in IDLE.
- tap_in  in  N: tap value returned by the upstream shift register for the current addr.
- addr  out  AW: registered tap select driven to the upstream shift register.
- busy  out  1: high in SCAN and DONE.
- coef_we  in  1: coefficient write strobe.
- coef_addr  in  AW: coefficient index.
- coef_data  in  C: coefficient value.
- result  out  N+C+AW: accumulated sum, 19 bits at defaults.
- valid  out  1: result valid.
- ready  in  1: consumer accepts result.

Function
REQ-005 The block SHALL hold TAPS coefficient registers; coef_we writes coef_data to coef[coef_addr] at the clock edge, only in IDLE; writes in SCAN or DONE are ignored.
REQ-006 The FSM SHALL have states IDLE, SCAN and DONE.
- IDLE goes to SCAN when start=1.
- SCAN goes to DONE after TAPS+1 cycles.
- DONE goes to IDLE on valid and ready.
REQ-007 On entering SCAN the block SHALL clear the accumulator and drive addr=0; addr increments by 1 each SCAN cycle through TAPS-1, then holds at TAPS-1 for the final drain cycle.
REQ-008 The block SHALL sample tap_in the cycle after the corresponding addr is presented (one-cycle tap latency); SCAN cycle k+1 adds coef[k]*tap_in, for k = 0..TAPS-1.
REQ-009 Products SHALL be unsigned N+C bits, zero-extended to the accumulator width N+C+AW; no overflow is possible and no saturation logic is required.
REQ-010 On the transition to DONE the block SHALL register the accumulator into result and assert valid; start-to-valid latency is TAPS+2 = 10 cycles.
REQ-011 result and valid SHALL hold stable while ready=0 in DONE.
REQ-012 On valid&ready, valid SHALL drop the next cycle and the FSM SHALL return to IDLE; start in that same cycle is ignored.
REQ-013 start SHALL be ignored outside IDLE.
REQ-014 In IDLE, addr SHALL be 0.
REQ-015 result SHALL retain its last value after the handshake until the next DONE.

Reset
REQ-016 When rst=0 at a clock edge, the block SHALL set state=IDLE, addr=0, accumulator=0, result=0, valid=0, busy=0 and all coef registers to 0.
REQ-017 Reset asserted mid-SCAN or in DONE SHALL abort the operation with no valid pulse; normal operation resumes the cycle after rst returns to 1.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding (IDLE, SCAN, DONE) and the default constants N, C, TAPS and AW.
REQ-019 The coefficient register file SHALL be one sub-module, coef_rf: a TAPS x C write-only-in-IDLE register array with an asynchronous read port.

Verification
REQ-020 The bench SHALL model the upstream shift register as tap_in = addr+1 (registered, one-cycle latency) and cover these scenarios:
- All coef=1, start pulse -> valid rises exactly 10 cycles after start with result=36.
- coef[k]=k, tap_in=addr+1 -> result=sum k*(k+1) for k=0..7, i.e. 168.
- All coef=255, tap_in forced to 255 -> result=520200, with no wrap.
- ready=0 for 5 cycles in DONE with start pulsed -> result and valid stable, start ignored; ready=1 -> valid=0 next cycle, busy=0.
- coef_we during SCAN (coef[0]=99) -> current and next result are unaffected; coef[0] is unchanged.
- rst=0 at SCAN cycle 4 -> next cycle state IDLE, addr=0, busy=0, valid=0; a new start yields the correct result.
